uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with majority-vote sampling, 1/2 stop bits, per-frame error flags
//  and an output FIFO with a valid/ready handshake.

---
 rtl/uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with error flags and FWFT output FIFO
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int BAUD_RATE       = 1_562_500,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int NUM_DATA_BITS   = 8,
  parameter int PARITY_ON       = 1,
  parameter int PARITY_EO       = 1,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_rx,
  output logic [NUM_DATA_BITS-1:0]       o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count,
  output logic                           o_busy,
  output logic                           o_parity_err,
  output logic                           o_frame_err,
  output logic                           o_overrun,
  output logic                           o_break
);

  localparam int     OS      = OVERSAMPLE_RATE;
  localparam int     N       = NUM_DATA_BITS;
  localparam longint BAUD_OS = longint'(BAUD_RATE) * longint'(OS);
  localparam int     DIV_RAW = int'((longint'(CLK_FREQ_HZ) + BAUD_OS / 2) / BAUD_OS);
  localparam int     DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int     TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int     OW      = $clog2(OS);
  localparam int     PW      = $clog2(FIFO_DEPTH);
  localparam int     CW      = PW + 1;
  localparam bit     PARAMS_OK =
      (OS == 8 || OS == 16) && (N >= 5 && N <= 9) &&
      (PARITY_ON == 0 || PARITY_ON == 1) && (PARITY_EO == 0 || PARITY_EO == 1) &&
      (STOP_BITS == 1 || STOP_BITS == 2) && (FIFO_DEPTH >= 2) &&
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  if (!PARAMS_OK) begin : g_param_err
    $error("uart_rx_fifo: parameter out of range");
  end
  if (DIV_RAW < 1) begin : g_div_err
    $error("uart_rx_fifo: clock too slow for baud rate and oversample rate");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_sync, rx_prev;
  logic [TW-1:0]   tick_cnt;
  logic [OW-1:0]   os_cnt;
  logic            samp_a, samp_b;
  logic [N-1:0]    shreg;
  logic [3:0]      bit_idx;
  logic            stop_idx;
  logic            par_bit, ferr_acc;
  logic            frame_done, brk_det;
  logic [N-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  wire start_edge = rx_prev & ~rx_sync;
  wire tick       = (tick_cnt == TW'(DIV - 1));
  wire mid_tick   = tick && (os_cnt == OW'(OS / 2 + 1));
  wire end_tick   = tick && (os_cnt == OW'(OS - 1));
  wire bit_val    = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  wire par_exp    = (PARITY_EO != 0);
  wire perr_now   = (PARITY_ON != 0) && ((^shreg ^ par_bit) != par_exp);
  wire ferr_now   = ferr_acc | ~bit_val;
  wire push_req   = frame_done & ~perr_now & ~ferr_now & ~brk_det;
  wire full       = (count == CW'(FIFO_DEPTH));
  wire do_pop     = (count != '0) & i_ready;
  wire do_push    = push_req & (~full | do_pop);

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Oversample tick and tick-within-bit counters, re-phased on every start edge
  always_ff @(posedge i_clk) begin
    if (i_rst || (state == S_IDLE && start_edge)) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (state == S_BREAK && !rx_sync) os_cnt <= '0;
      else if (tick)                    os_cnt <= os_cnt + OW'(1);
    end
  end

  // Frame datapath: mid-bit samples, data shift register, bit/stop indices
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (tick && os_cnt == OW'(OS / 2 - 1)) samp_a <= rx_sync;
      if (tick && os_cnt == OW'(OS / 2))     samp_b <= rx_sync;
      if (state == S_IDLE) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (mid_tick) begin
        case (state)
          S_DATA:   shreg   <= {bit_val, shreg[N-1:1]};
          S_PARITY: par_bit <= bit_val;
          S_STOP:   if (!bit_val) ferr_acc <= 1'b1;
          default:  ;
        endcase
      end
      if (end_tick) begin
        if (state == S_DATA) bit_idx  <= bit_idx + 4'd1;
        if (state == S_STOP) stop_idx <= 1'b1;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic zero_acc;
  wire  zero_now = zero_acc & (stop_idx | ~bit_val);
  assign brk_det = frame_done & zero_now;

  // Tracks whether every bit so far in this frame sampled low
  always_ff @(posedge i_clk) begin
    if (i_rst || state == S_IDLE) zero_acc <= 1'b1;
    else if (mid_tick && state != S_BREAK) zero_acc <= zero_acc & ~bit_val;
  end

  // Break pulse register
  always_ff @(posedge i_clk) begin
    if (i_rst) o_break <= 1'b0;
    else       o_break <= brk_det;
  end
`else
  assign brk_det = 1'b0;
  assign o_break = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state; frame_done marks the last stop bit's mid-bit decision
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:   if (start_edge) state_next = S_START;
      S_START:  if (mid_tick && bit_val) state_next = S_IDLE;
                else if (end_tick)      state_next = S_DATA;
      S_DATA:   if (end_tick && bit_idx == 4'(N - 1))
                  state_next = (PARITY_ON != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (end_tick) state_next = S_STOP;
      S_STOP:   if (mid_tick && stop_idx == 1'(STOP_BITS - 1)) begin
                  frame_done = 1'b1;
                  state_next = brk_det ? S_BREAK : S_IDLE;
                end
      S_BREAK:  if (end_tick && rx_sync) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Error pulses, registered so they appear the cycle after completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_parity_err <= frame_done & perr_now & ~brk_det;
      o_frame_err  <= frame_done & ferr_now & ~brk_det;
      o_overrun    <= push_req & full & ~do_pop;
    end
  end

  // Output FIFO; count is kept separately so full and empty never alias
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign o_data       = mem[rd_ptr];
  assign o_valid      = (count != '0);
  assign o_fifo_count = count;
  assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo at default parameters (8O1, 64 clk/bit)
module tb_uart_rx_fifo;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic [4:0] o_fifo_count;
  logic       o_busy, o_parity_err, o_frame_err, o_overrun, o_break;

  int n_chk = 0;
  int n_fail = 0;
  int n_perr = 0, n_ferr = 0, n_ovr = 0, n_brk = 0;

  uart_rx_fifo dut (
    .i_clk(clk), .i_rst(i_rst), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_fifo_count(o_fifo_count), .o_busy(o_busy),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err), .o_overrun(o_overrun),
    .o_break(o_break)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_parity_err) n_perr++;
    if (o_frame_err)  n_ferr++;
    if (o_overrun)    n_ovr++;
    if (o_break)      n_brk++;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_push;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic line(input logic b, input int n);
    i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    line(p, BIT);
    line(s, BIT);
    i_rx = 1'b1;
  endtask

  task automatic idle_busy(input int n, output int busy_n);
    busy_n = 0;
    i_rx = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_busy) busy_n++;
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  vec_t vecs[8];
  int b_perr, b_ferr, b_ovr, b_brk, lat, busy_n;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1, 0};
    vecs[2] = '{8'h81, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[3] = '{8'h55, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 1, 1};
    vecs[7] = '{8'h7F, 1'b0, 1'b1, 1'b1, 0, 0};

    repeat (5) @(negedge clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_count", int'(o_fifo_count), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_perr", int'(o_parity_err), 0);
    chk("rst_ferr", int'(o_frame_err), 0);
    chk("rst_ovr", int'(o_overrun), 0);
    chk("rst_brk", int'(o_break), 0);
    i_rst = 1'b0;
    line(1'b1, 20);

    // first frame: latency from start edge to o_valid
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      for (int c = 1; c <= 1000 && lat < 0; c++) begin
        @(negedge clk);
        if (o_valid) lat = c;
      end
    join
    chk("latency_in_window", int'(lat >= 640 && lat <= 700), 1);
    chk("first_data", int'(o_data), 8'hA5);
    chk("first_count", int'(o_fifo_count), 1);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("first_pop_count", int'(o_fifo_count), 0);

    // table-driven single frames
    for (int v = 0; v < 8; v++) begin
      b_perr = n_perr; b_ferr = n_ferr; b_brk = n_brk;
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      line(1'b1, 40);
      chk($sformatf("v%0d_perr", v), n_perr - b_perr, vecs[v].exp_perr);
      chk($sformatf("v%0d_ferr", v), n_ferr - b_ferr, vecs[v].exp_ferr);
      chk($sformatf("v%0d_brk", v), n_brk - b_brk, 0);
      chk($sformatf("v%0d_count", v), int'(o_fifo_count), int'(vecs[v].exp_push));
      if (vecs[v].exp_push) chk($sformatf("v%0d_data", v), int'(o_data), int'(vecs[v].data));
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      chk($sformatf("v%0d_empty", v), int'(o_valid), 0);
    end

    // fill the FIFO with the consumer stalled, then overflow by one
    b_ovr = n_ovr;
    for (int k = 0; k < 17; k++) begin
      send_frame(8'(k), odd_par(8'(k)), 1'b1);
      if (k == 15) begin
        chk("fill_count16", int'(o_fifo_count), 16);
        chk("fill_no_ovr", n_ovr - b_ovr, 0);
      end
    end
    line(1'b1, 40);
    chk("ovr_pulse", n_ovr - b_ovr, 1);
    chk("ovr_count", int'(o_fifo_count), 16);
    i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_data%0d", k), int'(o_data), k);
      @(negedge clk);
    end
    i_ready = 1'b0;
    chk("drain_valid", int'(o_valid), 0);
    chk("drain_count", int'(o_fifo_count), 0);

    // glitches on the idle line
    b_perr = n_perr; b_ferr = n_ferr;
    line(1'b0, 4);
    idle_busy(120, busy_n);
    chk("glitch4_short_busy", int'(busy_n > 0 && busy_n < BIT), 1);
    line(1'b0, 20);
    idle_busy(120, busy_n);
    chk("glitch20_short_busy", int'(busy_n > 0 && busy_n < BIT), 1);
    chk("glitch_flags", (n_perr - b_perr) + (n_ferr - b_ferr), 0);
    chk("glitch_count", int'(o_fifo_count), 0);
    chk("glitch_idle", int'(o_busy), 0);

    // reset in the middle of a frame
    send_frame(8'h55, 1'b1, 1'b1);
    line(1'b1, 40);
    chk("pre_rst_count", int'(o_fifo_count), 1);
    line(1'b0, BIT);
    line(1'b0, BIT);
    line(1'b1, 3 * BIT);
    chk("pre_rst_busy", int'(o_busy), 1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_count", int'(o_fifo_count), 0);
    chk("mid_rst_data", int'(o_data), 0);
    i_rst = 1'b0;
    b_perr = n_perr; b_ferr = n_ferr;
    line(1'b1, 300);
    chk("post_rst_quiet", (n_perr - b_perr) + (n_ferr - b_ferr) + int'(o_fifo_count), 0);
    send_frame(8'h42, 1'b1, 1'b1);
    line(1'b1, 40);
    chk("post_rst_data", int'(o_data), 8'h42);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;

    // long low line (break)
    b_ferr = n_ferr; b_brk = n_brk; b_perr = n_perr;
    line(1'b0, 15 * BIT);
    line(1'b1, 200);
`ifdef UART_RX_BREAK_DET_EN
    chk("break_pulse", n_brk - b_brk, 1);
    chk("break_no_ferr", n_ferr - b_ferr, 0);
    chk("break_no_perr", n_perr - b_perr, 0);
`else
    chk("break_tied_low", n_brk - b_brk, 0);
    chk("break_as_ferr", n_ferr - b_ferr, 1);
`endif
    chk("break_no_push", int'(o_fifo_count), 0);
    send_frame(8'h55, 1'b1, 1'b1);
    line(1'b1, 40);
    chk("after_break_count", int'(o_fifo_count), 1);
    chk("after_break_data", int'(o_data), 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
